// File: rtl/audio_sfx_scheduler_pkg.sv
// Shared types and constants for the audio SFX scheduler.
// Holds the FSM state encoding, the SFX ROM map and the saturating adder.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_FETCH_BGM = 3'd2,
    ST_LATCH_BGM = 3'd3,
    ST_FETCH_SFX = 3'd4,
    ST_LATCH_SFX = 3'd5,
    ST_MIX       = 3'd6
  } state_e;

  localparam int SFX_AW = 17;

  // SFX regions sit directly above the BGM stream
  // 0: line clear, 1: drop, 2: rotate, 3: game over
  localparam logic [SFX_AW-1:0] SFX_BASE [4] = '{
    17'd83466,
    17'd83514,
    17'd83546,
    17'd83570
  };

  localparam logic [SFX_AW-1:0] SFX_LAST [4] = '{
    17'd83513,
    17'd83545,
    17'd83569,
    17'd83633
  };

  // Signed add clamped to a w-bit two's complement range
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    r  = s;
    if (s > hi) r = hi;
    if (s < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/audio_sfx_scheduler_if.sv
// Codec and sample-ROM bundle for the audio SFX scheduler.
// master: scheduler side. slave: codec + ROM side.
interface audio_sfx_scheduler_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);

  logic              INIT_FINISH;
  logic              data_over;
  logic              INIT;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;

  modport master (
    input  INIT_FINISH,
    input  data_over,
    input  rom_data,
    output INIT,
    output rom_addr,
    output sample_out,
    output sample_valid
  );

  modport slave (
    output INIT_FINISH,
    output data_over,
    output rom_data,
    input  INIT,
    input  rom_addr,
    input  sample_out,
    input  sample_valid
  );

endinterface

// File: rtl/audio_sfx_scheduler_tick_div.sv
// Sample-period divider: counts 0..DIV-1 while enabled, else holds 0.
// Ports: Clk, Reset, en (count enable), tick (high on the last count).
module audio_tick_div #(
  parameter int DIV = 121
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (!en) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/audio_sfx_scheduler.sv
// BGM + SFX sample scheduler sharing one single-port sample ROM.
// Ports: Clk, Reset, bus (codec init/handshake + ROM), sfx_trigger/
// sfx_id (game SFX request), sfx_busy/sfx_cur (SFX status).
// Build option: AUDIO_SFX_DUCK_EN halves BGM while an SFX is mixed.
module audio_sfx_scheduler
  import audio_pkg::*;
#(
  parameter int          DIV      = 121,
  parameter int          ADDR_W   = 17,
  parameter int          DATA_W   = 16,
  parameter int unsigned BGM_BASE = 0,
  parameter int unsigned BGM_LAST = 83465
) (
  input  logic                  Clk,
  input  logic                  Reset,
  audio_sfx_scheduler_if.master bus,
  input  logic                  sfx_trigger,
  input  logic [1:0]            sfx_id,
  output logic                  sfx_busy,
  output logic [1:0]            sfx_cur
);

  localparam logic [2:0] WAIT_INIT = ST_WAIT_INIT;
  localparam logic [2:0] IDLE      = ST_IDLE;
  localparam logic [2:0] FETCH_BGM = ST_FETCH_BGM;
  localparam logic [2:0] LATCH_BGM = ST_LATCH_BGM;
  localparam logic [2:0] FETCH_SFX = ST_FETCH_SFX;
  localparam logic [2:0] LATCH_SFX = ST_LATCH_SFX;
  localparam logic [2:0] MIX       = ST_MIX;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BGM_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BGM_LAST);

  logic [2:0]               state;
  logic                     div_en;
  logic                     tick;
  logic                     adv;
  logic                     mix_sfx;
  logic                     retrig;
  logic                     trig_ok;
  logic                     sfx_step;
  logic                     in_sfx_fetch;
  logic [ADDR_W-1:0]        bgm_ptr;
  logic [ADDR_W-1:0]        sfx_ptr;
  logic signed [DATA_W-1:0] bgm_s;
  logic signed [DATA_W-1:0] sfx_s;
  logic signed [DATA_W-1:0] bgm_term;
  logic signed [DATA_W-1:0] sfx_term;
  logic signed [31:0]       mix_w;

  assign div_en = (state != WAIT_INIT);

  audio_tick_div #(
    .DIV (DIV)
  ) u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (div_en),
    .tick  (tick)
  );

  assign trig_ok = sfx_trigger
                && (state != WAIT_INIT)
                && (!sfx_busy || (sfx_id >= sfx_cur));

  // Window in which the SFX pointer is already committed to a fetch
  assign in_sfx_fetch = (state == LATCH_BGM)
                     || (state == FETCH_SFX)
                     || (state == LATCH_SFX);

  // Only step the SFX that was actually played this period
  assign sfx_step = (state == MIX) && adv
                 && mix_sfx && !retrig;

  assign sfx_term = mix_sfx ? sfx_s : '0;

`ifdef AUDIO_SFX_DUCK_EN
  assign bgm_term = mix_sfx ? (bgm_s >>> 1) : bgm_s;
`else
  assign bgm_term = bgm_s;
`endif

  assign mix_w = sat_add(32'(bgm_term), 32'(sfx_term), DATA_W);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= WAIT_INIT;
      bus.INIT         <= 1'b0;
      bus.rom_addr     <= BASE_A;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      bgm_ptr          <= BASE_A;
      bgm_s            <= '0;
      sfx_s            <= '0;
      adv              <= 1'b0;
      mix_sfx          <= 1'b0;
    end else begin
      bus.INIT         <= 1'b1;
      bus.sample_valid <= (state == MIX);
      unique case (state)
        WAIT_INIT: begin
          if (bus.INIT_FINISH) state <= IDLE;
        end
        IDLE: begin
          if (tick) begin
            state        <= FETCH_BGM;
            adv          <= bus.data_over;
            bus.rom_addr <= bgm_ptr;
          end
        end
        FETCH_BGM: begin
          state <= LATCH_BGM;
        end
        LATCH_BGM: begin
          bgm_s   <= $signed(bus.rom_data);
          mix_sfx <= sfx_busy;
          if (sfx_busy) begin
            state        <= FETCH_SFX;
            bus.rom_addr <= sfx_ptr;
          end else begin
            state <= MIX;
          end
        end
        FETCH_SFX: begin
          state <= LATCH_SFX;
        end
        LATCH_SFX: begin
          sfx_s <= $signed(bus.rom_data);
          state <= MIX;
        end
        MIX: begin
          bus.sample_out <= DATA_W'(mix_w);
          if (adv) begin
            bgm_ptr <= (bgm_ptr == LAST_A)
                     ? BASE_A
                     : bgm_ptr + ADDR_W'(1);
          end
          state <= IDLE;
        end
        default: begin
          state <= WAIT_INIT;
        end
      endcase
    end
  end

  // A trigger always wins over the end-of-SFX clear in MIX.
  // retrig marks a restart after the SFX address was issued, so
  // the new SFX is not stepped past its first sample.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sfx_busy <= 1'b0;
      sfx_cur  <= 2'd0;
      sfx_ptr  <= '0;
      retrig   <= 1'b0;
    end else begin
      if (trig_ok) begin
        sfx_busy <= 1'b1;
        sfx_cur  <= sfx_id;
        sfx_ptr  <= ADDR_W'(SFX_BASE[sfx_id]);
      end else if (sfx_step) begin
        if (sfx_ptr == ADDR_W'(SFX_LAST[sfx_cur])) begin
          sfx_busy <= 1'b0;
        end else begin
          sfx_ptr <= sfx_ptr + ADDR_W'(1);
        end
      end
      if (state == MIX) begin
        retrig <= 1'b0;
      end else if (trig_ok && in_sfx_fetch) begin
        retrig <= 1'b1;
      end
    end
  end

endmodule
